// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes engine: inverse affine transform followed by GF(2^8)
// inversion as x^254, one byte per 8 cycles, valid/ready on both sides.
module inv_sub_bytes_seq #(
  parameter int unsigned NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_state
);

  localparam int unsigned KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [2:0]          s_q, s_d;
  logic [7:0]          base_q, base_d;
  logic [7:0]          res_q, res_d;
  logic [8*NBYTES-1:0] buf_q, buf_d;
  logic [8*NBYTES-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;

  logic [7:0] cur_byte;
  logic [7:0] sq;
  logic [7:0] prod;

  // Polynomial multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] invaff(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == KW'(i)) cur_byte = buf_q[8*(NBYTES-1-i) +: 8];
    end
  end

  // Square-and-multiply: res accumulates base^(2+4+...+128) = base^254.
  assign sq   = gf_mul(base_q, base_q);
  assign prod = gf_mul(res_q, sq);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    s_d         = s_q;
    base_d      = base_q;
    res_d       = res_q;
    buf_d       = buf_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_state;
          k_d     = '0;
          s_d     = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (s_q == 3'd0) begin
          base_d = invaff(cur_byte);
          res_d  = 8'h01;
          s_d    = 3'd1;
        end else begin
          base_d = sq;
          res_d  = prod;
          s_d    = s_q + 3'd1;
          if (s_q == 3'd7) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
              if (k_q == KW'(i)) out_d[8*(NBYTES-1-i) +: 8] = prod;
            end
            if (k_q == KLAST) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      s_q         <= '0;
      base_q      <= '0;
      res_q       <= '0;
      buf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s_q         <= s_d;
      base_q      <= base_d;
      res_q       <= res_d;
      buf_q       <= buf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_state = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: directed vectors, full byte sweep,
// back-pressure, mid-operation reset and back-to-back throughput.
module tb_inv_sub_bytes_seq;

  localparam int unsigned N = 16;
  localparam int unsigned W = 8 * N;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_state;

  int n_checks;
  int n_errors;

  logic [7:0] sbox_tbl [256];
  logic [7:0] isbox_tbl[256];

  inv_sub_bytes_seq #(.NBYTES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Forward S-box built by brute-force inversion plus the forward affine map.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      a = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tbl[x] = a;
    end
    for (int x = 0; x < 256; x++) isbox_tbl[sbox_tbl[x]] = 8'(x);
  endtask

  function automatic logic [W-1:0] model_inv(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[8*(N-1-k) +: 8] = isbox_tbl[d[8*(N-1-k) +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] model_fwd(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[8*(N-1-k) +: 8] = sbox_tbl[d[8*(N-1-k) +: 8]];
    return r;
  endfunction

  task automatic do_op(input logic [W-1:0] din, output logic [W-1:0] dout);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", W'(in_ready), W'(1));
    in_state = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = ~din;
    check("busy_in_ready", W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", W'(lat), W'(128));
    dout = out_state;
  endtask

  task automatic finish_op();
    check("done_in_ready", W'(in_ready), W'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", W'(out_valid), W'(0));
    check("hs_in_ready", W'(in_ready), W'(1));
  endtask

  logic [W-1:0] v1, e1, v2, e2, din, r, held;
  logic [W-1:0] vec[3];
  logic [W-1:0] got[3];
  int acc[3];
  int na, nr, c, bad;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    build_tables();

    v1 = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
    e1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    v2 = {8'h00, 8'h63, 8'h16, 8'h7c, {12{8'h52}}};
    e2 = {8'h52, 8'h00, 8'hff, 8'h01, {12{8'h48}}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_state", out_state, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", W'(in_ready), W'(1));

    do_op(v1, r);
    check("fips_vector", r, e1);
    repeat (5) @(posedge clk);
    #1;
    check("hold_out_valid", W'(out_valid), W'(1));
    check("hold_out_state", out_state, e1);
    finish_op();

    do_op(v2, r);
    check("edge_bytes", r, e2);
    finish_op();
    check("kept_after_hs", out_state, e2);

    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 16; k++) din[8*(N-1-k) +: 8] = 8'(16 * p + k);
      do_op(din, r);
      finish_op();
      check($sformatf("sweep_inv_%0d", p), r, model_inv(din));
      check($sformatf("sweep_fwd_%0d", p), model_fwd(r), din);
    end

    // Back-pressure with noisy inputs while the result is pending.
    do_op(v1, held);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom_range(0, 1));
      in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (in_ready !== 1'b0) bad++;
      if (out_state !== e1 || out_valid !== 1'b1) bad++;
    end
    check("bp_violations", W'(bad), W'(0));
    check("bp_out_state", out_state, e1);
    in_valid = 1'b0;
    finish_op();

    // Reset while BUSY with k=5, s=3.
    in_state = v2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_state", out_state, '0);
    rst = 1'b0;
    check("midrst_in_ready", W'(in_ready), W'(1));
    repeat (150) @(posedge clk);
    #1;
    check("midrst_no_result", W'(out_valid), W'(0));
    do_op(v1, r);
    check("post_rst_result", r, e1);
    finish_op();

    // Back-to-back with in_valid held high and out_ready high.
    vec[0] = v1;
    vec[1] = v2;
    for (int k = 0; k < 16; k++) vec[2][8*(N-1-k) +: 8] = 8'(16 + k);
    for (int i = 0; i < 3; i++) begin
      acc[i] = 0;
      got[i] = '0;
    end
    na = 0;
    nr = 0;
    c  = 0;
    out_ready = 1'b1;
    in_state  = vec[0];
    in_valid  = 1'b1;
    while (nr < 3 && c < 1000) begin
      if (in_valid) begin
        if (in_ready) begin
          acc[na] = c;
          na++;
        end else if (na < 3) begin
          in_state = vec[na];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid && nr < 3) begin
        got[nr] = out_state;
        nr++;
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_results", W'(nr), W'(3));
    check("b2b_spacing_0", W'(acc[1] - acc[0]), W'(130));
    check("b2b_spacing_1", W'(acc[2] - acc[1]), W'(130));
    check("b2b_res_0", got[0], e1);
    check("b2b_res_1", got[1], e2);
    check("b2b_res_2", got[2], model_inv(vec[2]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Iterative InvSubBytes engine for the AES decryption datapath.
- Applies the inverse AES S-box to every byte of a NBYTES-byte state using arithmetic only (no lookup table): inverse affine transform, then GF(2^8) inversion by exponentiation (x^254).
- Trades latency for area; sits between InvShiftRows and AddRoundKey in the iterative decrypt round.
- Valid/ready handshake on both sides.

Parameters:
- NBYTES, 16, number of bytes in the state; byte k occupies bits [8*NBYTES-1-8k -: 8], so byte 0 is the MSB byte.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  engine idle and can accept; equals (state==IDLE).
- in_state  input  8*NBYTES  ciphertext-side state to substitute.
- out_valid  output  1  out_state holds the result.
- out_ready  input  1  consumer accepts the result.
- out_state  output  8*NBYTES  InvSubBytes(in_state).

Behaviour:
- Reset, sampled on clk edge: state=IDLE, out_valid=0, out_state=0, internal buffers/counters=0; in_ready=1 from the first cycle after rst deasserts. rst overrides everything, including a BUSY operation mid-flight: the partial result is discarded and no out_valid is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE: on an edge with in_valid&&in_ready, capture in_state into the working buffer; byte index k=0, step s=0; go to BUSY. in_valid is ignored in any other state.
- BUSY, per byte, 8 cycles:
  - s=0: base <= invaff(byte k); res <= 8'h01.
  - s=1..7: base <= base^2 and res <= res*(base^2), using the new squared value within the same cycle.
  - At s=7, the computed res (= base0^254, which is 0 for input 0) is written into byte k of the output buffer. If k==NBYTES-1, go to DONE with out_valid<=1. Otherwise k<=k+1 and s<=0.
- invaff(b) = rotl(b,1) ^ rotl(b,3) ^ rotl(b,6) ^ 8'h05. Rotations are 8-bit circular left.
- GF multiply is polynomial multiplication mod x^8+x^4+x^3+x+1 (0x11B), purely combinational within one cycle. Squaring uses the same multiplier or a dedicated squarer; results must be identical.
- Latency: with acceptance at edge T, out_valid is high after edge T+8*NBYTES (T+128 at default). Throughput is one state per 8*NBYTES+2 cycles minimum.
- DONE: out_valid=1 and out_state is held stable until out_ready. On an edge with out_valid&&out_ready, out_valid<=0 and the FSM goes to IDLE.
  - in_ready rises the cycle after the output handshake; there is no same-cycle accept/complete overlap.
  - out_state keeps its last value after the handshake; it is not cleared.
- in_state may change freely after acceptance; the engine uses only its captured copy.
- Back-pressure: out_ready low in DONE holds indefinitely. in_ready stays 0 throughout BUSY and DONE.

Test Plan:
- Reset, then single state in_state=128'h637c777b_f26b6fc5_3001672b_fed7ab76 -> after 128 cycles out_state=128'h00010203_04050607_08090a0b_0c0d0e0f, out_valid stays high until out_ready.
- Edge bytes: in_state = byte0 8'h00, byte1 8'h63, byte2 8'h16, byte3 8'h7c, remaining bytes 8'h52 -> out bytes 8'h52, 8'h00, 8'hff, 8'h01, remaining 8'h48.
- Exhaustive sweep over 16 passes covering inputs 8'h00..8'hff -> each output byte equals the FIPS-197 inverse S-box entry, and forward S-box(out) equals the input.
- Back-pressure: hold out_ready=0 for 50 cycles in DONE while toggling in_valid and in_state -> out_state stable, in_ready=0, no new capture. Release -> in_ready=1 exactly one cycle after the handshake.
- Mid-operation reset: assert rst at BUSY byte 5 step 3 -> next cycle out_valid=0 and out_state=0, then in_ready=1. A fresh state completes in 128 cycles with a correct result.
- Back-to-back: in_valid held high with out_ready=1 -> accept-to-accept spacing of 130 cycles, with results in order.
